// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and input validation for the BCD <-> binary converters.
package bcd_pkg;

  localparam int BCD_W = 10;
  localparam int BIN_W = 8;
  localparam int STEPS = 8;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(STEPS);

  localparam logic [3:0] DIG_THRESH = 4'd8;
  localparam logic [3:0] DIG_SUB    = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a digit is not decimal or the encoded value exceeds 255.
  function automatic logic bcd_invalid(input logic [BCD_W-1:0] bcd);
    logic [7:0] tens_ones;
    tens_ones = 8'(bcd[7:4]) * 8'd10 + 8'(bcd[3:0]);
    return (bcd[3:0] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[9:8] == 2'd3) ||
           ((bcd[9:8] == 2'd2) && (tens_ones > 8'd55));
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a field that reached 8 after the shift loses 3.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= DIG_THRESH) ? (i_digit - DIG_SUB) : i_digit;

endmodule

// File: rtl/bcd_bin.sv
// Sequential 3-digit BCD to 8-bit binary converter, one reverse double-dabble step per cycle.
//
// state | meaning
// IDLE  | waiting for din_vld; captures bcd_in on the strobe
// CONV  | one shift/correct step per cycle, counter 0..7
// DONE  | result just published; returns to IDLE next edge
module bcd_bin
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BCD_W-1:0] bcd_in,
  input  logic             din_vld,
  output logic [BIN_W-1:0] bin_out,
  output logic             dout_vld,
  output logic             busy,
  output logic             err
);

  state_t           r_state;
  state_t           w_state_next;
  logic [SR_W-1:0]  r_sr;
  logic [SR_W-1:0]  w_shift;
  logic [SR_W-1:0]  w_sr_step;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_cap;
  logic             w_load;
  logic             w_last;
  logic [3:0]       w_h_adj;
  logic [3:0]       w_t_adj;
  logic [3:0]       w_o_adj;
  logic [1:0]       w_unused_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (din_vld) begin
          w_load       = 1'b1;
          w_state_next = CONV;
        end
      end
      CONV: begin
        if (r_cnt == CNT_W'(STEPS - 1)) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Register layout: [17:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary result.
  assign w_shift = r_sr >> 1;

  bcd_digit_adj u_adj_h (.i_digit({2'b00, w_shift[17:16]}), .o_digit(w_h_adj));
  bcd_digit_adj u_adj_t (.i_digit(w_shift[15:12]),          .o_digit(w_t_adj));
  bcd_digit_adj u_adj_o (.i_digit(w_shift[11:8]),           .o_digit(w_o_adj));

  // After a right shift the 2-bit hundreds field never reaches 8, so its upper bits stay zero.
  assign w_unused_h = w_h_adj[3:2];
  assign w_sr_step  = {w_h_adj[1:0], w_t_adj, w_o_adj, w_shift[BIN_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr      <= '0;
      r_cnt     <= '0;
      r_err_cap <= 1'b0;
      bin_out   <= '0;
      dout_vld  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      dout_vld <= w_last;
      busy     <= (w_state_next != IDLE);
      if (w_load) begin
        r_sr      <= {bcd_in, {BIN_W{1'b0}}};
        r_cnt     <= '0;
        r_err_cap <= bcd_invalid(bcd_in);
      end else if (r_state == CONV) begin
        r_sr  <= w_sr_step;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        bin_out <= r_err_cap ? '0 : w_sr_step[BIN_W-1:0];
        err     <= r_err_cap;
      end
    end
  end

endmodule

// File: tb/tb_bcd_bin.sv
// Self-checking bench for bcd_bin: directed cases, exhaustive sweep and random codes vs. an arithmetic model.
module tb_bcd_bin;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic [9:0] bcd_in = '0;
  logic       din_vld = 1'b0;
  logic [7:0] bin_out;
  logic       dout_vld;
  logic       busy;
  logic       err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] hold_bin = '0;
  logic       hold_err = 1'b0;

  always #5 clk = ~clk;

  bcd_bin dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bcd_in   (bcd_in),
    .din_vld  (din_vld),
    .bin_out  (bin_out),
    .dout_vld (dout_vld),
    .busy     (busy),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input logic [9:0] code, output logic [7:0] b, output logic e);
    int h, t, o, v;
    h = int'(code[9:8]);
    t = int'(code[7:4]);
    o = int'(code[3:0]);
    v = h * 100 + t * 10 + o;
    e = (o > 9) || (t > 9) || (v > 255);
    b = e ? 8'd0 : v[7:0];
  endfunction

  // Pulse one conversion and check every cycle from E0 to E9.
  task automatic run_conv(input logic [9:0] code, input bit repulse, input logic [9:0] code2);
    logic [7:0] eb;
    logic       ee;
    ref_model(code, eb, ee);
    @(negedge clk);
    bcd_in  = code;
    din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
    bcd_in  = 10'($urandom);
    chk("busy_e0", busy, 1);
    chk("dvld_e0", dout_vld, 0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("dvld_mid", dout_vld, 0);
      chk("bin_hold", bin_out, hold_bin);
      chk("err_hold", err, hold_err);
      chk("busy_mid", busy, 1);
      if (repulse && k == 2) begin
        bcd_in  = code2;
        din_vld = 1'b1;
      end
      if (repulse && k == 3) din_vld = 1'b0;
    end
    @(negedge clk);
    chk("dvld_e8", dout_vld, 1);
    chk("bin_e8", bin_out, eb);
    chk("err_e8", err, ee);
    chk("busy_e8", busy, 1);
    hold_bin = eb;
    hold_err = ee;
    @(negedge clk);
    chk("dvld_e9", dout_vld, 0);
    chk("busy_e9", busy, 0);
    chk("bin_e9", bin_out, hold_bin);
    chk("err_e9", err, hold_err);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #3;
    chk("rst_bin", bin_out, 0);
    chk("rst_dvld", dout_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_conv(10'h165, 1'b0, 10'h000);
    run_conv(10'h240, 1'b0, 10'h000);
    run_conv(10'h255, 1'b0, 10'h000);
    run_conv(10'h000, 1'b0, 10'h000);
    run_conv(10'h256, 1'b0, 10'h000);
    run_conv(10'h1A3, 1'b0, 10'h000);
    run_conv(10'h30F, 1'b0, 10'h000);

    // A second strobe inside CONV must be dropped entirely.
    run_conv(10'h123, 1'b1, 10'h045);
    repeat (12) begin
      @(negedge clk);
      chk("no_second_dvld", dout_vld, 0);
      chk("no_second_busy", busy, 0);
      chk("no_second_bin", bin_out, hold_bin);
    end

    // Abort between E4 and E5.
    run_conv(10'h200, 1'b0, 10'h000);
    @(negedge clk);
    bcd_in  = 10'h199;
    din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_bin", bin_out, 0);
    chk("abort_dvld", dout_vld, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_bin = 8'd0;
    hold_err = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_dvld", dout_vld, 0);
      chk("abort_idle_busy", busy, 0);
    end
    run_conv(10'h087, 1'b0, 10'h000);

    for (int c = 0; c < 1024; c++) run_conv(10'(c), 1'b0, 10'h000);

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_conv(10'($urandom_range(0, 1023)), 1'b0, 10'h000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
